// File: rtl/loader_pkg.sv
// Shared types and constants for the boot loader: FSM states, image header layout.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COUNT_LO = 3'd1,
        COUNT_HI = 3'd2,
        DATA     = 3'd3,
        WRITE    = 3'd4,
        RUN      = 3'd5
    } state_t;

    localparam logic [7:0]  MAGIC_DEFAULT  = 8'hA5;

    // Image layout: magic, count low byte, count high byte, then payload words.
    localparam int unsigned POS_MAGIC      = 0;
    localparam int unsigned POS_N_LO       = 1;
    localparam int unsigned POS_N_HI       = 2;
    localparam int unsigned POS_PAYLOAD    = 3;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned COUNT_W        = 16;

endpackage

// File: rtl/word_assembler.sv
// Packs four received bytes into a little-endian 32-bit word; first byte lands in [7:0].
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        byte_idx,
    output logic              word_done
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift) begin
            word     <= {byte_in, word[WORD_W-1:8]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign word_done = shift && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/boot_loader_ctrl.sv
// Loads a UART-streamed program image into RAM with the core held in reset,
// then hands the RAM port to the core.
module boot_loader_ctrl
    import loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS      = 1024,
    parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         cpu_rst,
    input  logic [31:0]  cpu_mem_addr,
    input  logic         cpu_mem_rstrb,
    input  logic [31:0]  cpu_mem_wdata,
    input  logic [3:0]   cpu_mem_wmask,
    output logic [31:0]  ram_addr,
    output logic         ram_rstrb,
    output logic [31:0]  ram_wdata,
    output logic [3:0]   ram_wmask,
    output logic         err,
    output logic [15:0]  words_loaded
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state, state_next;
    logic [COUNT_W-1:0]  n_words, n_words_next;
    logic [COUNT_W-1:0]  loaded_next;
    logic                err_next;
    logic [CNT_W-1:0]    idle_cnt, idle_cnt_next;
    logic                accept;
    logic                asm_shift, asm_clear;
    logic [WORD_W-1:0]   asm_word;
    logic [1:0]          asm_idx;
    logic                asm_done;
    logic [COUNT_W-1:0]  n_full;

    assign rx_ready = (state != WRITE);
    assign cpu_rst  = (state != RUN);
    assign accept   = rx_valid && rx_ready;
    assign n_full   = {rx_data, n_words[7:0]};

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .shift     (asm_shift),
        .byte_in   (rx_data),
        .word      (asm_word),
        .byte_idx  (asm_idx),
        .word_done (asm_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            n_words      <= '0;
            words_loaded <= '0;
            err          <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            state        <= state_next;
            n_words      <= n_words_next;
            words_loaded <= loaded_next;
            err          <= err_next;
            idle_cnt     <= idle_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        n_words_next  = n_words;
        loaded_next   = words_loaded;
        err_next      = err;
        idle_cnt_next = '0;
        asm_shift     = 1'b0;
        asm_clear     = 1'b0;

        unique case (state)
            IDLE, RUN: begin
                if (accept && rx_data == MAGIC) begin
                    state_next  = COUNT_LO;
                    err_next    = 1'b0;
                    loaded_next = '0;
                    asm_clear   = 1'b1;
                end
            end
            COUNT_LO: begin
                if (accept) begin
                    n_words_next[7:0] = rx_data;
                    state_next        = COUNT_HI;
                end
            end
            COUNT_HI: begin
                if (accept) begin
                    n_words_next = n_full;
                    if (n_full == '0) begin
                        state_next = RUN;
                    end else if (32'(n_full) > MEM_WORDS) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_done) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                loaded_next = words_loaded + COUNT_W'(1);
                state_next  = (loaded_next == n_words) ? RUN : DATA;
            end
            default: state_next = IDLE;
        endcase

        // Inter-byte watchdog while an image header or payload is in flight.
        if ((state == COUNT_LO || state == COUNT_HI || state == DATA) && !accept) begin
            if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                err_next   = 1'b1;
                state_next = IDLE;
                asm_clear  = 1'b1;
            end else begin
                idle_cnt_next = idle_cnt + CNT_W'(1);
            end
        end
    end

    // RAM port: core passthrough in RUN, loader-owned otherwise.
    always_comb begin
        ram_addr  = '0;
        ram_rstrb = 1'b0;
        ram_wdata = asm_word;
        ram_wmask = 4'b0000;
        if (state == RUN) begin
            ram_addr  = cpu_mem_addr;
            ram_rstrb = cpu_mem_rstrb;
            ram_wdata = cpu_mem_wdata;
            ram_wmask = cpu_mem_wmask;
        end else if (state == WRITE) begin
            ram_addr  = 32'({words_loaded, 2'b00});
            ram_wmask = 4'b1111;
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: byte-stream vectors plus a RAM write scoreboard.
module tb_boot_loader_ctrl;
    import loader_pkg::*;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned TIMEOUT   = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        cpu_rst;
    logic [31:0] cpu_mem_addr;
    logic        cpu_mem_rstrb;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wmask;
    logic [31:0] ram_addr;
    logic        ram_rstrb;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wmask;
    logic        err;
    logic [15:0] words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [7:0]  b;
        logic        cpu_rst;
        logic        rdy;
        logic [15:0] wl;
    } vec_t;
    vec_t vecs[11];

    boot_loader_ctrl #(
        .MEM_WORDS      (MEM_WORDS),
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .cpu_rst       (cpu_rst),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_rstrb (cpu_mem_rstrb),
        .cpu_mem_wdata (cpu_mem_wdata),
        .cpu_mem_wmask (cpu_mem_wmask),
        .ram_addr      (ram_addr),
        .ram_rstrb     (ram_rstrb),
        .ram_wdata     (ram_wdata),
        .ram_wmask     (ram_wmask),
        .err           (err),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Loader writes are matched in order against what the stimulus promised.
    always @(negedge clk) begin
        if (rst === 1'b0 && cpu_rst === 1'b1 && ram_wmask !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h mask %b expected none at %0t",
                         ram_addr, ram_wdata, ram_wmask, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", ram_addr, e.addr);
                check("wr_data", ram_wdata, e.data);
                check("wr_mask", 32'(ram_wmask), 32'hF);
                check("wr_rx_ready", 32'(rx_ready), 32'd0);
            end
        end
    end

    // Returns #1 after the accepting edge so callers sample the post-accept state.
    task automatic send_byte(input logic [7:0] b);
        int waits;
        waits = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (!rx_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_ready_stuck: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input int idx, input logic [31:0] w);
        wr_t e;
        e.addr = 32'(idx) << 2;
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'hA5, 1'b1, 1'b1, 16'd0};
        vecs[1]  = '{8'h02, 1'b1, 1'b1, 16'd0};
        vecs[2]  = '{8'h00, 1'b1, 1'b1, 16'd0};
        vecs[3]  = '{8'h13, 1'b1, 1'b1, 16'd0};
        vecs[4]  = '{8'h05, 1'b1, 1'b1, 16'd0};
        vecs[5]  = '{8'h10, 1'b1, 1'b1, 16'd0};
        vecs[6]  = '{8'h00, 1'b1, 1'b0, 16'd0};
        vecs[7]  = '{8'h73, 1'b1, 1'b1, 16'd1};
        vecs[8]  = '{8'h00, 1'b1, 1'b1, 16'd1};
        vecs[9]  = '{8'h10, 1'b1, 1'b1, 16'd1};
        vecs[10] = '{8'h00, 1'b1, 1'b0, 16'd1};

        rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
        cpu_mem_addr = '0; cpu_mem_rstrb = 1'b0; cpu_mem_wdata = '0; cpu_mem_wmask = '0;
        tick(2);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wmask", 32'(ram_wmask), 32'd0);
        check("rst_rstrb", 32'(ram_rstrb), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        @(negedge clk) rst = 1'b0;

        send_byte(8'h00);
        send_byte(8'h13);
        check("idle_junk_state", 32'(dut.state), 32'(IDLE));

        // Two-word image; the byte after each 4th byte lands in WRITE and must wait.
        exp_q.push_back('{32'h0, 32'h00100513});
        exp_q.push_back('{32'h4, 32'h00100073});
        for (int i = 0; i < 11; i++) begin
            send_byte(vecs[i].b);
            check($sformatf("vec%0d_cpu_rst", i), 32'(cpu_rst), 32'(vecs[i].cpu_rst));
            check($sformatf("vec%0d_rx_ready", i), 32'(rx_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_words", i), 32'(words_loaded), 32'(vecs[i].wl));
        end
        tick(1);
        check("run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("run_words", 32'(words_loaded), 32'd2);
        cpu_mem_addr = 32'h8; cpu_mem_rstrb = 1'b1; cpu_mem_wdata = 32'hDEADBEEF;
        #1;
        check("pass_addr", ram_addr, 32'h8);
        check("pass_rstrb", 32'(ram_rstrb), 32'd1);
        check("pass_wdata", ram_wdata, 32'hDEADBEEF);

        send_byte(8'h00);
        check("run_drop_cpu_rst", 32'(cpu_rst), 32'd0);
        send_byte(8'hA5);
        check("rerun_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rerun_rstrb", 32'(ram_rstrb), 32'd0);
        check("rerun_words", 32'(words_loaded), 32'd0);

        // N = 1025 exceeds capacity.
        send_byte(8'h01);
        send_byte(8'h04);
        check("big_err", 32'(err), 32'd1);
        check("big_state", 32'(dut.state), 32'(IDLE));
        check("big_cpu_rst", 32'(cpu_rst), 32'd1);
        send_byte(8'hA5);
        check("magic_clears_err", 32'(err), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        check("n0_state", 32'(dut.state), 32'(RUN));
        check("n0_cpu_rst", 32'(cpu_rst), 32'd0);

        // Stall mid-word until the watchdog fires.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        tick(TIMEOUT - 3);
        check("pre_to_state", 32'(dut.state), 32'(DATA));
        check("pre_to_err", 32'(err), 32'd0);
        tick(6);
        check("to_err", 32'(err), 32'd1);
        check("to_state", 32'(dut.state), 32'(IDLE));
        check("to_idx", 32'(dut.u_asm.byte_idx), 32'd0);
        check("to_cpu_rst", 32'(cpu_rst), 32'd1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_word(0, 32'h11223344);
        tick(1);
        check("rec_state", 32'(dut.state), 32'(RUN));
        check("rec_err", 32'(err), 32'd0);

        // Synchronous reset mid-word must discard the partial word.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        @(negedge clk) rst = 1'b1;
        tick(2);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        check("mid_rst_idx", 32'(dut.u_asm.byte_idx), 32'd0);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        @(negedge clk) rst = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_word(0, 32'hCAFEF00D);
        send_word(1, 32'h01234567);
        tick(1);
        check("fresh_state", 32'(dut.state), 32'(RUN));
        check("fresh_words", 32'(words_loaded), 32'd2);

        // Full-capacity image: last write at 4*(MEM_WORDS-1).
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
        check("full_state", 32'(dut.state), 32'(DATA));
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            send_word(i, $urandom);
        end
        tick(1);
        check("full_state_run", 32'(dut.state), 32'(RUN));
        check("full_words", 32'(words_loaded), 32'(MEM_WORDS));
        check("full_err", 32'(err), 32'd0);

        tick(2);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
